// File: rtl/uart_rx_param_if.sv
// Receive-side bundle for uart_rx_param: serial line in, decoded word and status out.
// The receiver binds to the master modport; the consuming logic binds to slave.
interface uart_rx_param_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 rx_serial;   // asynchronous serial line, idle high
  logic                 rx_dv;       // one-cycle frame-complete strobe
  logic [DATA_BITS-1:0] rx_data;     // received word, held until next rx_dv
  logic                 frame_err;   // a stop bit sampled low
  logic                 parity_err;  // parity mismatch (0 when parity is compiled out)
  logic                 rx_break;    // all-zero data, parity and first stop bit
  logic                 busy;        // receiver is not idle

  modport master (
    input  rx_serial,
    output rx_dv,
    output rx_data,
    output frame_err,
    output parity_err,
    output rx_break,
    output busy
  );

  modport slave (
    output rx_serial,
    input  rx_dv,
    input  rx_data,
    input  frame_err,
    input  parity_err,
    input  rx_break,
    input  busy
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with 3-sample majority vote per bit, 1 or 2 stop bits,
// and framing / parity / break reporting. One word per frame with a one-cycle strobe.
// Optional parity bit is compiled in with the macro UART_RX_PARITY_EN.
module uart_rx_param #(
  parameter int unsigned CLKS_PER_BIT = 1042,
  parameter int unsigned DATA_BITS    = 8,
  parameter bit          PARITY_ODD   = 1'b0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic            i_Clock,
  input  logic            i_rst,
  uart_rx_param_if.master rx_if
);

  localparam int unsigned     CntW        = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CntW-1:0] CntHalf     = CntW'(CLKS_PER_BIT / 2);
  localparam logic [CntW-1:0] CntLast     = CntW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      IdxLastData = 4'(DATA_BITS - 1);
  localparam logic [3:0]      IdxLastStop = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StCleanup,
    StWaitHigh
  } state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic [2:0]           hist_q, hist_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 ferr_acc_q, ferr_acc_d;  // any stop bit low so far
  logic                 stop0_q, stop0_d;        // first stop bit sample
  logic                 dv_q, dv_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 frame_err_q, frame_err_d;
  logic                 break_q, break_d;
  logic                 maj;
  logic                 first_stop;
  logic                 par_low;                 // parity bit absent or sampled 0
`ifdef UART_RX_PARITY_EN
  logic                 par_bit_q, par_bit_d;
  logic                 parity_err_q, parity_err_d;
`endif

  assign maj = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

  // With one stop bit, the first stop bit is the one being sampled right now.
  assign first_stop = (idx_q == 4'd0) ? maj : stop0_q;

`ifdef UART_RX_PARITY_EN
  assign par_low = ~par_bit_q;
`else
  assign par_low = 1'b1;
`endif

  // Next-state logic: synchroniser, vote history, frame FSM and output capture.
  always_comb begin
    sync1_d     = rx_if.rx_serial;
    sync2_d     = sync1_q;
    hist_d      = {hist_q[1:0], sync2_q};
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    ferr_acc_d  = ferr_acc_q;
    stop0_d     = stop0_q;
    dv_d        = 1'b0;
    data_d      = data_q;
    frame_err_d = frame_err_q;
    break_d     = break_q;
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = parity_err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (!sync2_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end

      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          if (!maj) begin
            state_d = StData;
            idx_d   = 4'd0;
          end else begin
            state_d = StIdle;  // too short to be a start bit
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StData: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          for (int unsigned b = 0; b < DATA_BITS; b++) begin
            if (idx_q == 4'(b)) shreg_d[b] = maj;
          end
          idx_d = idx_q + 4'd1;
          if (idx_q == IdxLastData) begin
            idx_d      = 4'd0;
            ferr_acc_d = 1'b0;
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q == CntLast) begin
          cnt_d     = '0;
          par_bit_d = maj;
          state_d   = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`endif

      StStop: begin
        if (cnt_q == CntLast) begin
          cnt_d      = '0;
          ferr_acc_d = ferr_acc_q | ~maj;
          if (idx_q == 4'd0) stop0_d = maj;
          if (idx_q == IdxLastStop) begin
            state_d     = StCleanup;
            dv_d        = 1'b1;
            data_d      = shreg_q;
            frame_err_d = ferr_acc_q | ~maj;
            break_d     = (shreg_q == '0) && par_low && !first_stop;
`ifdef UART_RX_PARITY_EN
            parity_err_d = ((^shreg_q) ^ par_bit_q) != PARITY_ODD;
`endif
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StCleanup: begin
        // A low stop bit may be a held break: wait for the line to recover.
        state_d = frame_err_q ? StWaitHigh : StIdle;
      end

      StWaitHigh: begin
        if (sync2_q) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge i_Clock) begin
    if (i_rst) begin
      state_q     <= StIdle;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      hist_q      <= 3'b111;
      cnt_q       <= '0;
      idx_q       <= 4'd0;
      shreg_q     <= '0;
      ferr_acc_q  <= 1'b0;
      stop0_q     <= 1'b1;
      dv_q        <= 1'b0;
      data_q      <= '0;
      frame_err_q <= 1'b0;
      break_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      hist_q      <= hist_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      ferr_acc_q  <= ferr_acc_d;
      stop0_q     <= stop0_d;
      dv_q        <= dv_d;
      data_q      <= data_d;
      frame_err_q <= frame_err_d;
      break_q     <= break_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_if.rx_dv     = dv_q;
  assign rx_if.rx_data   = data_q;
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.rx_break  = break_q;
  assign rx_if.busy      = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
  assign rx_if.parity_err = parity_err_q;
`else
  assign rx_if.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: frames are pushed as expected responses when sent,
// and a monitor pops and compares on every rx_dv strobe. Two receivers are exercised:
// A (8 data bits, 1 stop) and B (7 data bits, 2 stop), both with CLKS_PER_BIT = 16.
module tb_uart_rx_param;

  localparam int unsigned Cpb    = 16;
  localparam bit          ParOdd = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam bit HasPar = 1'b1;
`else
  localparam bit HasPar = 1'b0;
`endif

  typedef struct packed {
    logic [8:0] data;
    logic       ferr;
    logic       perr;
    logic       brk;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_fail = 0;
  rsp_t qa[$];
  rsp_t qb[$];

  uart_rx_param_if #(.DATA_BITS(8)) ifa ();
  uart_rx_param_if #(.DATA_BITS(7)) ifb ();

  uart_rx_param #(
    .CLKS_PER_BIT(Cpb),
    .DATA_BITS   (8),
    .PARITY_ODD  (ParOdd),
    .STOP_BITS   (1)
  ) dut_a (
    .i_Clock(clk),
    .i_rst  (rst),
    .rx_if  (ifa)
  );

  uart_rx_param #(
    .CLKS_PER_BIT(Cpb),
    .DATA_BITS   (7),
    .PARITY_ODD  (ParOdd),
    .STOP_BITS   (2)
  ) dut_b (
    .i_Clock(clk),
    .i_rst  (rst),
    .rx_if  (ifb)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expected word.
  always @(negedge clk) begin
    rsp_t act;
    rsp_t exp;
    if (ifa.rx_dv === 1'b1) begin
      act = '{data: {1'b0, ifa.rx_data}, ferr: ifa.frame_err, perr: ifa.parity_err,
              brk: ifa.rx_break};
      if (qa.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL a_unexpected_dv: got word 0x%0h, want no strobe", act);
      end else begin
        exp = qa.pop_front();
        check("a_word", 32'(act), 32'(exp));
      end
    end
    if (ifb.rx_dv === 1'b1) begin
      act = '{data: {2'b00, ifb.rx_data}, ferr: ifb.frame_err, perr: ifb.parity_err,
              brk: ifb.rx_break};
      if (qb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL b_unexpected_dv: got word 0x%0h, want no strobe", act);
      end else begin
        exp = qb.pop_front();
        check("b_word", 32'(act), 32'(exp));
      end
    end
  end

  task automatic drive(input bit sel, input bit v, input int n);
    if (sel) ifb.rx_serial = v;
    else     ifa.rx_serial = v;
    repeat (n) @(negedge clk);
  endtask

  // One frame: start, data LSB first, optional parity, stop bit(s). gbit selects a data bit
  // that gets a one-cycle inverted glitch in its middle (-1 for none).
  task automatic send(input bit sel, input logic [8:0] d, input bit par, input bit s0,
                      input bit s1, input int gbit);
    int         nb;
    int         ns;
    logic [8:0] dm;
    rsp_t       e;
    nb = sel ? 7 : 8;
    ns = sel ? 2 : 1;
    dm = d & ((9'd1 << nb) - 9'd1);
    e.data = dm;
    e.ferr = !s0 || (ns == 2 && !s1);
    e.perr = HasPar && (((^dm) ^ par) != ParOdd);
    e.brk  = (dm == 9'd0) && (!HasPar || !par) && !s0;
    if (sel) qb.push_back(e);
    else     qa.push_back(e);
    drive(sel, 1'b0, Cpb);
    for (int i = 0; i < nb; i++) begin
      if (i == gbit) begin
        drive(sel, dm[i], Cpb / 2);
        drive(sel, !dm[i], 1);
        drive(sel, dm[i], Cpb / 2 - 1);
      end else begin
        drive(sel, dm[i], Cpb);
      end
    end
    if (HasPar) drive(sel, par, Cpb);
    drive(sel, s0, Cpb);
    if (ns == 2) drive(sel, s1, Cpb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] w;
    ifa.rx_serial = 1'b1;
    ifb.rx_serial = 1'b1;
    repeat (3) @(negedge clk);
    check("a_reset_outputs", {ifa.rx_dv, ifa.rx_data, ifa.frame_err, ifa.parity_err,
                              ifa.rx_break, ifa.busy}, 32'd0);
    check("b_reset_outputs", {ifb.rx_dv, ifb.rx_data, ifb.frame_err, ifb.parity_err,
                              ifb.rx_break, ifb.busy}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Plain frame 0xA5.
    send(1'b0, 9'h0A5, 1'b0, 1'b1, 1'b1, -1);
    drive(1'b0, 1'b1, 2 * Cpb);

    // Reset during data bit 4 of an all-ones word: outputs clear, no strobe.
    drive(1'b0, 1'b0, Cpb);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, Cpb);
    drive(1'b0, 1'b1, Cpb / 2);
    rst = 1'b1;
    @(negedge clk);
    check("a_mid_frame_reset", {ifa.rx_dv, ifa.rx_data, ifa.frame_err, ifa.parity_err,
                                ifa.rx_break, ifa.busy}, 32'd0);
    rst = 1'b0;
    drive(1'b0, 1'b1, 4 * Cpb);
    send(1'b0, 9'h081, 1'b0, 1'b1, 1'b1, -1);
    drive(1'b0, 1'b1, 2 * Cpb);

    // One-cycle low glitch on an idle line: START entered, then abandoned.
    drive(1'b0, 1'b0, 1);
    drive(1'b0, 1'b1, 4);
    check("a_glitch_start_busy", 32'(ifa.busy), 32'd1);
    drive(1'b0, 1'b1, 12);
    check("a_glitch_back_idle", 32'(ifa.busy), 32'd0);
    drive(1'b0, 1'b1, 2 * Cpb);

    // One-cycle high glitch in the middle of data bit 5 of 0x0F.
    send(1'b0, 9'h00F, 1'b0, 1'b1, 1'b1, 5);
    drive(1'b0, 1'b1, 2 * Cpb);

    // Stop bit low with 0x3C: framing error, not a break.
    send(1'b0, 9'h03C, 1'b0, 1'b0, 1'b1, -1);
    drive(1'b0, 1'b1, 2 * Cpb);

    // Line held low for 40 bit times: exactly one break word.
    qa.push_back('{data: 9'd0, ferr: 1'b1, perr: 1'b0, brk: 1'b1});
    drive(1'b0, 1'b0, 40 * Cpb);
    drive(1'b0, 1'b1, 3 * Cpb);

    // 16 back-to-back frames at exact baud.
    for (int k = 0; k < 16; k++) begin
      w = 9'(k);
      send(1'b0, w, ^w, 1'b1, 1'b1, -1);
    end
    drive(1'b0, 1'b1, 2 * Cpb);

    // Receiver B: parity good, parity bad, second stop bit low.
    send(1'b1, 9'h055, 1'b0, 1'b1, 1'b1, -1);
    drive(1'b1, 1'b1, Cpb);
    send(1'b1, 9'h055, 1'b1, 1'b1, 1'b1, -1);
    drive(1'b1, 1'b1, Cpb);
    send(1'b1, 9'h012, 1'b0, 1'b1, 1'b0, -1);
    drive(1'b1, 1'b1, 3 * Cpb);

    check("a_all_words_seen", 32'(qa.size()), 32'd0);
    check("b_all_words_seen", 32'(qb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
